// File: rtl/addsub_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_arbiter_pkg
// Purpose : Shared widths and types for the two-requester add/subtract
//           arbiter: operand/result widths, FSM state enum, requester index.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package addsub_arbiter_pkg;

  localparam int OPND_W = 3;  // signed operand width
  localparam int RES_W  = 4;  // exact signed result width

  typedef logic signed [OPND_W-1:0] opnd_t;
  typedef logic signed [RES_W-1:0]  res_t;
  typedef logic                     req_id_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage : addsub_arbiter_pkg
`default_nettype wire

// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : addsub_arbiter_if
// Purpose : Request/response bundle between two requesters, the arbiter and
//           the result consumer.
// Ports   : req0_*/req1_* : valid, ready, a, b, sub per requester
//           rsp_*         : valid, ready, id, sum, ov, digit
//           modport master: requester/consumer side (testbench, upstream)
//           modport slave : arbiter side
// Revision: 1.0  initial release
// ============================================================================
interface addsub_arbiter_if;

  logic                         req0_valid;
  logic                         req0_ready;
  addsub_arbiter_pkg::opnd_t    req0_a;
  addsub_arbiter_pkg::opnd_t    req0_b;
  logic                         req0_sub;

  logic                         req1_valid;
  logic                         req1_ready;
  addsub_arbiter_pkg::opnd_t    req1_a;
  addsub_arbiter_pkg::opnd_t    req1_b;
  logic                         req1_sub;

  logic                         rsp_valid;
  logic                         rsp_ready;
  addsub_arbiter_pkg::req_id_t  rsp_id;
  logic [2:0]                   rsp_sum;
  logic                         rsp_ov;
  logic [3:0]                   rsp_digit;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_ov, rsp_digit,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_ov, rsp_digit,
    input  rsp_ready
  );

endinterface : addsub_arbiter_if
`default_nettype wire

// File: rtl/addsub_arbiter_unit.sv
`default_nettype none
// ============================================================================
// Module  : addsub_unit
// Purpose : Combinational signed 3-bit add/subtract with exact 4-bit result.
// Ports   : a, b  in  3  signed operands
//           sub   in  1  0 = a+b, 1 = a-b
//           digit out 4  exact signed result (-8..+7)
//           sum   out 3  low 3 bits of digit
//           ov    out 1  result does not fit in signed 3 bits
// Revision: 1.0  initial release
// ============================================================================
module addsub_unit
  import addsub_arbiter_pkg::*;
(
  input  opnd_t      a,
  input  opnd_t      b,
  input  logic       sub,
  output res_t       digit,
  output logic [2:0] sum,
  output logic       ov
);

  // One extra bit is enough for any sum or difference of two 3-bit values.
  res_t a_ext;
  res_t b_ext;

  assign a_ext = {a[OPND_W-1], a};
  assign b_ext = {b[OPND_W-1], b};
  assign digit = sub ? (a_ext - b_ext) : (a_ext + b_ext);
  assign sum   = digit[2:0];
  // Fits in 3 bits exactly when the top two bits agree.
  assign ov    = digit[3] ^ digit[2];

endmodule : addsub_unit
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : addsub_arbiter
// Purpose : Round-robin arbiter between two add/subtract requesters feeding a
//           single registered result slot, plus a saturating count of
//           overflowed results handed to the consumer.
// Ports   : clk      in  1      clock, rising edge
//           rst_n    in  1      asynchronous active-low reset
//           bus      slave      request/response bundle (addsub_arbiter_if)
//           ov_count out CNT_W  overflowed results delivered, saturating
// Revision: 1.0  initial release
// ============================================================================
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  addsub_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]  ov_count
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_FULL = FULL;

  logic [0:0]  state_q;
  req_id_t     last_grant_q;
  req_id_t     rsp_id_q;
  logic [2:0]  rsp_sum_q;
  logic        rsp_ov_q;
  res_t        rsp_digit_q;
  logic [CNT_W-1:0] ov_count_q;

  logic        full;
  logic        slot_open;
  req_id_t     grant;
  logic        accept;
  logic        rsp_fire;
  opnd_t       sel_a;
  opnd_t       sel_b;
  logic        sel_sub;
  res_t        alu_digit;
  logic [2:0]  alu_sum;
  logic        alu_ov;

  assign full = (state_q == S_FULL);

  // Grant is purely combinational so a lone requester is never delayed;
  // only contention consults last_grant.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // The slot can take a new result if empty or being drained this cycle.
  // rst_n gating keeps both readys low while reset is held.
  assign slot_open      = rst_n && (!full || bus.rsp_ready);
  assign bus.req0_ready = slot_open && bus.req0_valid && !grant;
  assign bus.req1_ready = slot_open && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign rsp_fire       = full && bus.rsp_ready;

  assign sel_a   = grant ? bus.req1_a   : bus.req0_a;
  assign sel_b   = grant ? bus.req1_b   : bus.req0_b;
  assign sel_sub = grant ? bus.req1_sub : bus.req0_sub;

  addsub_unit u_alu (
    .a     (sel_a),
    .b     (sel_b),
    .sub   (sel_sub),
    .digit (alu_digit),
    .sum   (alu_sum),
    .ov    (alu_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_ov_q     <= 1'b0;
      rsp_digit_q  <= '0;
      ov_count_q   <= '0;
    end else begin
      if (rsp_fire && rsp_ov_q && (ov_count_q != {CNT_W{1'b1}})) begin
        ov_count_q <= ov_count_q + 1'b1;
      end
      if (accept) begin
        state_q      <= S_FULL;
        last_grant_q <= grant;
        rsp_id_q     <= grant;
        rsp_sum_q    <= alu_sum;
        rsp_ov_q     <= alu_ov;
        rsp_digit_q  <= alu_digit;
      end else if (rsp_fire) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign bus.rsp_valid = full;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_ov    = rsp_ov_q;
  assign bus.rsp_digit = rsp_digit_q;
  assign ov_count      = ov_count_q;

endmodule : addsub_arbiter
`default_nettype wire
